// File: rtl/fwa_pkg.sv
// Shared types and widths for the frame window accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a; the pixel stream is never stalled.
package fwa_pkg;

  localparam int ACC_W = 20;  // window accumulator width
  localparam int POS_W = 13;  // pixel coordinate width
  localparam int CNT_W = 16;  // completed-frame counter width
  localparam int CMP_W = 14;  // one spare bit so WIN_X0+WIN_W cannot wrap

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } fwa_state_t;

  // Zero-extend a coordinate to the comparison width.
  function automatic logic [CMP_W-1:0] to_cmp(input logic [POS_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/window_region_decode.sv
// Classifies a pixel coordinate against the active area, the window and its outline.
// Latency: purely combinational.
// Backpressure: none; evaluates whatever coordinate is presented.
//   x_pos, y_pos : pixel column / row
//   in_active    : coordinate lies inside the active picture
//   in_window    : coordinate lies inside the accumulation window
//   on_outline   : coordinate lies on the one-pixel window border
//   is_origin    : coordinate is (0,0), the first pixel of a frame
//   is_last      : coordinate is the last active pixel of a frame
module window_region_decode
  import fwa_pkg::*;
#(
  parameter int WIN_X0   = 288,
  parameter int WIN_Y0   = 208,
  parameter int WIN_W    = 64,
  parameter int WIN_H    = 64,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  output logic             in_active,
  output logic             in_window,
  output logic             on_outline,
  output logic             is_origin,
  output logic             is_last
);

  // Window edges: *_END is exclusive, *_LAST is the final inclusive column/row.
  localparam logic [CMP_W-1:0] X_FIRST = CMP_W'(WIN_X0);
  localparam logic [CMP_W-1:0] X_END   = CMP_W'(WIN_X0 + WIN_W);
  localparam logic [CMP_W-1:0] X_LAST  = CMP_W'(WIN_X0 + WIN_W - 1);
  localparam logic [CMP_W-1:0] Y_FIRST = CMP_W'(WIN_Y0);
  localparam logic [CMP_W-1:0] Y_END   = CMP_W'(WIN_Y0 + WIN_H);
  localparam logic [CMP_W-1:0] Y_LAST  = CMP_W'(WIN_Y0 + WIN_H - 1);
  localparam logic [CMP_W-1:0] H_END   = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] V_END   = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] H_LAST  = CMP_W'(H_ACTIVE - 1);
  localparam logic [CMP_W-1:0] V_LAST  = CMP_W'(V_ACTIVE - 1);

  logic [CMP_W-1:0] x_c;
  logic [CMP_W-1:0] y_c;
  logic             in_cols;
  logic             in_rows;

  always_comb begin
    x_c        = to_cmp(x_pos);
    y_c        = to_cmp(y_pos);
    in_cols    = (x_c >= X_FIRST) && (x_c < X_END);
    in_rows    = (y_c >= Y_FIRST) && (y_c < Y_END);
    in_active  = (x_c < H_END) && (y_c < V_END);
    in_window  = in_cols && in_rows;
    on_outline = (in_rows && ((x_c == X_FIRST) || (x_c == X_LAST))) ||
                 (in_cols && ((y_c == Y_FIRST) || (y_c == Y_LAST)));
    is_origin  = (x_c == '0) && (y_c == '0);
    is_last    = (x_c == H_LAST) && (y_c == V_LAST);
  end

endmodule

// File: rtl/frame_window_accumulator.sv
// Counts white pixels inside a fixed window per frame and publishes the total plus a threshold flag.
// Latency: oIS_BOUND 1 cycle after the pixel; oSUM_VALID 2 edges after the edge sampling the last pixel.
// Backpressure: none; pixels arriving while publishing or outside the active area are dropped.
//   iCLK, iRST_N            : pixel clock, async active-low reset
//   iPIX_VALID/iX_POS/iY_POS/iBIN : pixel qualifier, coordinates, binarized value
//   oIS_BOUND               : previous pixel lies on the window outline
//   oSUM/oCLASSIFIED        : last completed window count and (count > THRESH)
//   oSUM_VALID              : one-cycle strobe when oSUM/oCLASSIFIED update
//   oFRAME_CNT              : completed-frame counter, wraps silently
module frame_window_accumulator
  import fwa_pkg::*;
#(
  parameter int WIN_X0   = 288,
  parameter int WIN_Y0   = 208,
  parameter int WIN_W    = 64,
  parameter int WIN_H    = 64,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int THRESH   = 2048
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iPIX_VALID,
  input  logic [POS_W-1:0] iX_POS,
  input  logic [POS_W-1:0] iY_POS,
  input  logic             iBIN,
  output logic             oIS_BOUND,
  output logic [31:0]      oSUM,
  output logic             oSUM_VALID,
  output logic             oCLASSIFIED,
  output logic [CNT_W-1:0] oFRAME_CNT
);

  localparam logic [ACC_W-1:0] THRESH_A = ACC_W'(THRESH);

  logic in_active;
  logic in_window;
  logic on_outline;
  logic is_origin;
  logic is_last;

  window_region_decode #(
    .WIN_X0  (WIN_X0),
    .WIN_Y0  (WIN_Y0),
    .WIN_W   (WIN_W),
    .WIN_H   (WIN_H),
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_decode (
    .x_pos     (iX_POS),
    .y_pos     (iY_POS),
    .in_active (in_active),
    .in_window (in_window),
    .on_outline(on_outline),
    .is_origin (is_origin),
    .is_last   (is_last)
  );

  // Decoded pixel stage: the FSM works on these one cycle after sampling,
  // which is what sets the two-edge publish latency.
  logic pix_vld_q;  // valid and inside the active area
  logic origin_q;
  logic last_q;
  logic hit_q;      // white and inside the window

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pix_vld_q <= 1'b0;
      origin_q  <= 1'b0;
      last_q    <= 1'b0;
      hit_q     <= 1'b0;
      oIS_BOUND <= 1'b0;
    end else begin
      pix_vld_q <= iPIX_VALID && in_active;
      origin_q  <= is_origin;
      last_q    <= is_last;
      hit_q     <= in_window && iBIN;
      oIS_BOUND <= iPIX_VALID && on_outline;
    end
  end

  fwa_state_t       state_q;
  fwa_state_t       state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             publish;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_vld_q && origin_q) begin
          state_d = ACCUM;
          acc_d   = ACC_W'(hit_q);
        end
      end
      ACCUM: begin
        if (pix_vld_q) begin
          if (origin_q) begin
            // A fresh frame start aborts the partial one.
            acc_d = ACC_W'(hit_q);
          end else begin
            acc_d = acc_q + ACC_W'(hit_q);
            if (last_q) begin
              state_d = PUBLISH;
            end
          end
        end
      end
      PUBLISH: begin
        publish = 1'b1;
        acc_d   = '0;
        state_d = IDLE;
      end
      default: begin
        acc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      oSUM        <= '0;
      oSUM_VALID  <= 1'b0;
      oCLASSIFIED <= 1'b0;
      oFRAME_CNT  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      oSUM_VALID <= publish;
      if (publish) begin
        oSUM        <= 32'(acc_q);
        oCLASSIFIED <= acc_q > THRESH_A;
        oFRAME_CNT  <= oFRAME_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_window_accumulator.sv
// Directed bench for frame_window_accumulator with default parameters.
// Latency: checks the two-edge publish latency and one-cycle outline flag.
// Backpressure: n/a; the stimulus is a free-running pixel stream.
module tb_frame_window_accumulator;

  logic        iCLK;
  logic        iRST_N;
  logic        iPIX_VALID;
  logic [12:0] iX_POS;
  logic [12:0] iY_POS;
  logic        iBIN;
  logic        oIS_BOUND;
  logic [31:0] oSUM;
  logic        oSUM_VALID;
  logic        oCLASSIFIED;
  logic [15:0] oFRAME_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int pub_cnt  = 0;
  int bound_cnt = 0;

  frame_window_accumulator dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iPIX_VALID (iPIX_VALID),
    .iX_POS     (iX_POS),
    .iY_POS     (iY_POS),
    .iBIN       (iBIN),
    .oIS_BOUND  (oIS_BOUND),
    .oSUM       (oSUM),
    .oSUM_VALID (oSUM_VALID),
    .oCLASSIFIED(oCLASSIFIED),
    .oFRAME_CNT (oFRAME_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Cycle-accurate event counters sampled on the falling edge.
  always @(negedge iCLK) begin
    if (oSUM_VALID) pub_cnt++;
    if (oIS_BOUND) bound_cnt++;
  end

  // Present one pixel for one edge; returns 1 time unit after that edge.
  task automatic pix(input logic v, input int x, input int y, input logic b);
    iPIX_VALID = v;
    iX_POS     = 13'(x);
    iY_POS     = 13'(y);
    iBIN       = b;
    @(posedge iCLK);
    #1;
    iPIX_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  // Raster the 64x64 window; rows below white_rows are white.
  task automatic send_window(input int white_rows);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        pix(1'b1, 288 + x, 208 + y, logic'(y < white_rows));
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    pix(1'b1, 0, 0, 1'b1);
    pix(1'b1, 288, 208, 1'b1);
    pix(1'b1, 300, 220, 1'b1);
    pix(1'b1, 639, 479, 1'b1);
    pix(1'b1, 351, 271, 1'b1);
    n_checks++; if (oSUM !== 32'd0) begin n_fail++; $display("FAIL rst_sum: got %0d want 0", oSUM); end
    n_checks++; if (oSUM_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", oSUM_VALID); end
    n_checks++; if (oCLASSIFIED !== 1'b0) begin n_fail++; $display("FAIL rst_cls: got %b want 0", oCLASSIFIED); end
    n_checks++; if (oFRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", oFRAME_CNT); end
    n_checks++; if (oIS_BOUND !== 1'b0) begin n_fail++; $display("FAIL rst_bound: got %b want 0", oIS_BOUND); end
    n_checks++; if (pub_cnt != 0) begin n_fail++; $display("FAIL rst_pubs: got %0d want 0", pub_cnt); end
    n_checks++; if (bound_cnt != 0) begin n_fail++; $display("FAIL rst_bounds: got %0d want 0", bound_cnt); end
    iRST_N = 1'b1;
    idle(3);
    n_checks++; if (oSUM_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_rel_vld: got %b want 0", oSUM_VALID); end
  endtask

  task automatic test_all_white();
    int base;
    base = pub_cnt;
    pix(1'b1, 0, 0, 1'b1);
    pix(1'b1, 5, 5, 1'b1);
    pix(1'b1, 700, 100, 1'b1);
    pix(1'b1, 639, 0, 1'b1);
    send_window(64);
    pix(1'b1, 300, 600, 1'b1);
    pix(1'b1, 639, 479, 1'b1);
    n_checks++; if (oSUM_VALID !== 1'b0) begin n_fail++; $display("FAIL lat0: got %b want 0", oSUM_VALID); end
    idle(1);
    n_checks++; if (oSUM_VALID !== 1'b0) begin n_fail++; $display("FAIL lat1: got %b want 0", oSUM_VALID); end
    idle(1);
    n_checks++; if (oSUM_VALID !== 1'b1) begin n_fail++; $display("FAIL lat2: got %b want 1", oSUM_VALID); end
    n_checks++; if (oSUM !== 32'd4096) begin n_fail++; $display("FAIL white_sum: got %0d want 4096", oSUM); end
    n_checks++; if (oCLASSIFIED !== 1'b1) begin n_fail++; $display("FAIL white_cls: got %b want 1", oCLASSIFIED); end
    n_checks++; if (oFRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL white_cnt: got %0d want 1", oFRAME_CNT); end
    idle(3);
    n_checks++; if (oSUM_VALID !== 1'b0) begin n_fail++; $display("FAIL white_strobe_len: got %b want 0", oSUM_VALID); end
    n_checks++; if (pub_cnt - base != 1) begin n_fail++; $display("FAIL white_pubs: got %0d want 1", pub_cnt - base); end
    n_checks++; if (oSUM !== 32'd4096) begin n_fail++; $display("FAIL white_hold: got %0d want 4096", oSUM); end
  endtask

  task automatic test_half_window();
    pix(1'b1, 0, 0, 1'b0);
    send_window(32);
    pix(1'b1, 639, 479, 1'b0);
    idle(2);
    n_checks++; if (oSUM_VALID !== 1'b1) begin n_fail++; $display("FAIL half_vld: got %b want 1", oSUM_VALID); end
    n_checks++; if (oSUM !== 32'd2048) begin n_fail++; $display("FAIL half_sum: got %0d want 2048", oSUM); end
    n_checks++; if (oCLASSIFIED !== 1'b0) begin n_fail++; $display("FAIL half_cls: got %b want 0", oCLASSIFIED); end
    n_checks++; if (oFRAME_CNT !== 16'd2) begin n_fail++; $display("FAIL half_cnt: got %0d want 2", oFRAME_CNT); end
    idle(2);
    // One more white pixel tips it just over the threshold.
    pix(1'b1, 0, 0, 1'b0);
    send_window(32);
    pix(1'b1, 320, 250, 1'b1);
    pix(1'b1, 639, 479, 1'b0);
    idle(2);
    n_checks++; if (oSUM !== 32'd2049) begin n_fail++; $display("FAIL over_sum: got %0d want 2049", oSUM); end
    n_checks++; if (oCLASSIFIED !== 1'b1) begin n_fail++; $display("FAIL over_cls: got %b want 1", oCLASSIFIED); end
    n_checks++; if (oFRAME_CNT !== 16'd3) begin n_fail++; $display("FAIL over_cnt: got %0d want 3", oFRAME_CNT); end
    idle(2);
  endtask

  task automatic test_abort();
    int base;
    base = pub_cnt;
    pix(1'b1, 0, 0, 1'b1);
    for (int i = 0; i < 1000; i++) pix(1'b1, 288 + i % 64, 208 + i / 64, 1'b1);
    pix(1'b1, 0, 0, 1'b1);
    idle(4);
    n_checks++; if (pub_cnt != base) begin n_fail++; $display("FAIL abort_nopub: got %0d want %0d", pub_cnt, base); end
    n_checks++; if (oSUM !== 32'd2049) begin n_fail++; $display("FAIL abort_sum_held: got %0d want 2049", oSUM); end
    send_window(64);
    pix(1'b1, 639, 479, 1'b1);
    idle(2);
    n_checks++; if (oSUM_VALID !== 1'b1) begin n_fail++; $display("FAIL abort_vld: got %b want 1", oSUM_VALID); end
    n_checks++; if (oSUM !== 32'd4096) begin n_fail++; $display("FAIL abort_sum: got %0d want 4096", oSUM); end
    idle(2);
    n_checks++; if (pub_cnt - base != 1) begin n_fail++; $display("FAIL abort_pubs: got %0d want 1", pub_cnt - base); end
    n_checks++; if (oFRAME_CNT !== 16'd4) begin n_fail++; $display("FAIL abort_cnt: got %0d want 4", oFRAME_CNT); end
  endtask

  task automatic test_gaps_outline();
    int base;
    int bbase;
    logic exp_b;
    base  = pub_cnt;
    bbase = bound_cnt;
    pix(1'b1, 0, 0, 1'b1);
    pix(1'b0, 0, 0, 1'b1);
    for (int y = 208; y < 272; y++) begin
      for (int x = 288; x < 352; x++) begin
        pix(1'b1, x, y, 1'b1);
        exp_b = (x == 288) || (x == 351) || (y == 208) || (y == 271);
        n_checks++; if (oIS_BOUND !== exp_b) begin n_fail++; $display("FAIL bound_vld (%0d,%0d): got %b want %b", x, y, oIS_BOUND, exp_b); end
        pix(1'b0, x, y, 1'b1);
        n_checks++; if (oIS_BOUND !== 1'b0) begin n_fail++; $display("FAIL bound_gap (%0d,%0d): got %b want 0", x, y, oIS_BOUND); end
      end
    end
    pix(1'b1, 639, 479, 1'b1);
    idle(2);
    n_checks++; if (oSUM_VALID !== 1'b1) begin n_fail++; $display("FAIL gap_vld: got %b want 1", oSUM_VALID); end
    n_checks++; if (oSUM !== 32'd4096) begin n_fail++; $display("FAIL gap_sum: got %0d want 4096", oSUM); end
    idle(2);
    n_checks++; if (bound_cnt - bbase != 252) begin n_fail++; $display("FAIL bound_total: got %0d want 252", bound_cnt - bbase); end
    n_checks++; if (pub_cnt - base != 1) begin n_fail++; $display("FAIL gap_pubs: got %0d want 1", pub_cnt - base); end
    n_checks++; if (oFRAME_CNT !== 16'd5) begin n_fail++; $display("FAIL gap_cnt: got %0d want 5", oFRAME_CNT); end
  endtask

  task automatic test_mid_reset_wrap();
    int base;
    pix(1'b1, 0, 0, 1'b1);
    for (int i = 0; i < 500; i++) pix(1'b1, 288 + i % 64, 208 + i / 64, 1'b1);
    iRST_N = 1'b0;
    #1;
    n_checks++; if (oFRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", oFRAME_CNT); end
    n_checks++; if (oSUM !== 32'd0) begin n_fail++; $display("FAIL mid_rst_sum: got %0d want 0", oSUM); end
    idle(3);
    iRST_N = 1'b1;
    idle(1);
    // White window pixels before any frame start must not count.
    for (int i = 0; i < 100; i++) pix(1'b1, 288 + i % 64, 208 + i / 64, 1'b1);
    pix(1'b1, 0, 0, 1'b1);
    send_window(64);
    pix(1'b1, 639, 479, 1'b1);
    idle(2);
    n_checks++; if (oSUM_VALID !== 1'b1) begin n_fail++; $display("FAIL post_rst_vld: got %b want 1", oSUM_VALID); end
    n_checks++; if (oSUM !== 32'd4096) begin n_fail++; $display("FAIL post_rst_sum: got %0d want 4096", oSUM); end
    n_checks++; if (oFRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL post_rst_cnt: got %0d want 1", oFRAME_CNT); end
    idle(2);
    force dut.oFRAME_CNT = 16'hFFFF;
    idle(1);
    release dut.oFRAME_CNT;
    idle(1);
    base = pub_cnt;
    pix(1'b1, 0, 0, 1'b0);
    pix(1'b1, 639, 479, 1'b0);
    idle(2);
    n_checks++; if (oSUM_VALID !== 1'b1) begin n_fail++; $display("FAIL wrap_vld: got %b want 1", oSUM_VALID); end
    n_checks++; if (oFRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 0", oFRAME_CNT); end
    n_checks++; if (oSUM !== 32'd0) begin n_fail++; $display("FAIL wrap_sum: got %0d want 0", oSUM); end
    n_checks++; if (oCLASSIFIED !== 1'b0) begin n_fail++; $display("FAIL wrap_cls: got %b want 0", oCLASSIFIED); end
    idle(2);
    // A frame start landing during the publish cycle is dropped, so the
    // following pixels and last pixel must not produce a second publish.
    pix(1'b1, 0, 0, 1'b0);
    pix(1'b1, 639, 479, 1'b0);
    pix(1'b1, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) pix(1'b1, 288 + i, 208, 1'b1);
    pix(1'b1, 639, 479, 1'b1);
    idle(4);
    n_checks++; if (pub_cnt - base != 2) begin n_fail++; $display("FAIL pub_ignore_pubs: got %0d want 2", pub_cnt - base); end
    n_checks++; if (oFRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL pub_ignore_cnt: got %0d want 1", oFRAME_CNT); end
    n_checks++; if (oSUM !== 32'd0) begin n_fail++; $display("FAIL pub_ignore_sum: got %0d want 0", oSUM); end
  endtask

  initial begin
    iRST_N     = 1'b0;
    iPIX_VALID = 1'b0;
    iX_POS     = '0;
    iY_POS     = '0;
    iBIN       = 1'b0;
    test_reset();
    test_all_white();
    test_half_window();
    test_abort();
    test_gaps_outline();
    test_mid_reset_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_window_accumulator.md
FRAME_WINDOW_ACCUMULATOR -- requirements
Module: frame_window_accumulator

Interface
REQ-001 The parameter list SHALL be:
- WIN_X0, default 288: window left column.
- WIN_Y0, default 208: window top row.
- WIN_W, default 64: window width in pixels.
- WIN_H, default 64: window height in pixels.
- H_ACTIVE, default 640: active columns per line.
- V_ACTIVE, default 480: active lines per frame.
- THRESH, default 2048: classification threshold.
REQ-002 The port list SHALL be, clock and reset first:
- iCLK  in  1  pixel clock; the block has this one clock only.
- iRST_N  in  1  reset, asynchronous, active-low.
- iPIX_VALID  in  1  pixel qualifier; iX_POS, iY_POS and iBIN are sampled only when high.
- iX_POS  in  13  pixel column.
- iY_POS  in  13  pixel row.
- iBIN  in  1  binarized pixel value; 1 means white.
- oIS_BOUND  out  1  the pixel sampled on the previous edge lies on the window outline.
- oSUM  out  32  white-pixel count of the last completed window, zero-extended.
- oSUM_VALID  out  1  one-cycle strobe; oSUM and oCLASSIFIED were updated this cycle.
- oCLASSIFIED  out  1  oSUM > THRESH.
- oFRAME_CNT  out  16  count of completed frames.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCUM and PUBLISH.
REQ-004 IDLE -> ACCUM SHALL occur on a valid pixel at (0,0); that pixel SHALL be counted.
REQ-005 In ACCUM, each valid pixel with WIN_X0<=x<WIN_X0+WIN_W, WIN_Y0<=y<WIN_Y0+WIN_H and iBIN=1 SHALL increment a 20-bit accumulator by exactly 1.
REQ-006 Pixels with iPIX_VALID=0 SHALL have no effect on the accumulator or on the FSM.
REQ-007 ACCUM -> PUBLISH SHALL occur on the valid pixel at (H_ACTIVE-1, V_ACTIVE-1); that pixel SHALL be counted.
REQ-008 A valid pixel at (0,0) while in ACCUM SHALL abort the frame:
- the accumulator is cleared, then that pixel is counted;
- the FSM stays in ACCUM;
- no publish occurs.
REQ-009 In PUBLISH, for exactly one cycle, the block SHALL:
- register oSUM <= accumulator, oCLASSIFIED <= (accumulator > THRESH) and oSUM_VALID <= 1;
- increment oFRAME_CNT;
- clear the accumulator;
- return to IDLE.
REQ-010 Publish latency SHALL be fixed: oSUM_VALID is high in the cycle following the second rising edge after the edge that sampled the last pixel.
REQ-011 oSUM_VALID SHALL be high for exactly one cycle per completed frame. oSUM and oCLASSIFIED SHALL hold their values until the next publish.
REQ-012 Valid pixels arriving in PUBLISH SHALL be ignored.
REQ-013 Valid pixels outside the active area (x>=H_ACTIVE or y>=V_ACTIVE) SHALL be ignored in every state.
REQ-014 oIS_BOUND SHALL be registered with one-cycle latency and SHALL be 1 iff the sampled pixel is valid and either condition holds:
- x is WIN_X0 or WIN_X0+WIN_W-1, with y inside the window rows;
- y is WIN_Y0 or WIN_Y0+WIN_H-1, with x inside the window columns.
REQ-015 oFRAME_CNT SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-016 All window-bound comparisons SHALL be done at 14 bits unsigned so that WIN_X0+WIN_W cannot overflow.

Reset
REQ-017 While iRST_N=0, the FSM SHALL be in IDLE and the accumulator and all outputs SHALL be 0, independent of iCLK.
REQ-018 Reset asserted mid-ACCUM or mid-PUBLISH SHALL discard the partial frame. The next publish SHALL reflect only pixels received after a subsequent (0,0).

Structure
REQ-019 A shared package fwa_pkg SHALL hold:
- the state enum;
- the ACC_W=20, POS_W=13 and CNT_W=16 constants.
REQ-020 Window membership and outline decode SHALL live in one combinational sub-module, window_region_decode, instantiated once.

Verification
REQ-021 The bench SHALL cover these directed scenarios, all with default parameters:
- Reset: hold iRST_N low for 5 cycles while driving pixels -> all outputs 0, no oSUM_VALID.
- All-white frame: one full frame with iBIN=1 -> single oSUM_VALID, oSUM=4096, oCLASSIFIED=1, oFRAME_CNT=1.
- Half window: rows 208..239 white, rest black -> oSUM=2048, oCLASSIFIED=0 (not strictly greater).
- Abort: (0,0) reissued after 1000 white window pixels, then a full all-white frame -> exactly one oSUM_VALID, oSUM=4096.
- Gaps and outline: iPIX_VALID toggling every other cycle over an all-white frame -> oSUM=4096. oIS_BOUND high exactly 252 times, one cycle after each outline pixel.
- Mid-frame reset and wrap: reset in ACCUM, then a full frame -> oSUM correct and oFRAME_CNT=1. Preload 0xFFFF via 65535 short frames (or a force) -> next publish gives 0x0000.
